// File: rtl/rho_step_iter_if.sv
// Handshake and state bus for rho_step_iter.
// slave is the rho block's side, master is the producer/consumer side.
// States are packed [x][y][bit], so state[x][y] selects one lane.
interface rho_step_iter_if #(
  parameter int LANE_W = 64
);
  logic                            in_valid;
  logic                            in_ready;
  logic [4:0][4:0][LANE_W-1:0]     state_in;
  logic                            out_valid;
  logic                            out_ready;
  logic [4:0][4:0][LANE_W-1:0]     state_out;
  logic                            busy;

  modport slave (
    input  in_valid, state_in, out_ready,
    output in_ready, out_valid, state_out, busy
  );

  modport master (
    output in_valid, state_in, out_ready,
    input  in_ready, out_valid, state_out, busy
  );
endinterface

// File: rtl/rho_step_iter.sv
// Multi-cycle Keccak rho step.
// A full state is captured, then LANES_PER_CYCLE lanes are rotated per clock
// over N_ITER = 25/LANES_PER_CYCLE cycles, and the result is held until taken.
// Optional macro RHO_PI_EN: when defined, the output is pi(rho(A)), with pi
// applied as pure wiring on the working register.
module rho_step_iter #(
  parameter int LANE_W          = 64,
  parameter int LANES_PER_CYCLE = 5
) (
  input  logic             clk,
  input  logic             rst,
  rho_step_iter_if.slave   bus
);

  localparam int N_ITER = 25 / LANES_PER_CYCLE;
  localparam int CNT_W  = 5;

  typedef logic [4:0][4:0][LANE_W-1:0] state_arr_t;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ROTATE = 2'd1,
    S_DONE   = 2'd2
  } fsm_t;

  fsm_t             state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  state_arr_t       work_q,  work_d;

  // Rho offsets for lane i = x + 5*y, before reduction mod LANE_W.
  function automatic int rho_raw(input int i);
    case (i)
      0:  return 0;   1:  return 1;   2:  return 62;  3:  return 28;  4:  return 27;
      5:  return 36;  6:  return 44;  7:  return 6;   8:  return 55;  9:  return 20;
      10: return 3;   11: return 10;  12: return 43;  13: return 25;  14: return 39;
      15: return 41;  16: return 45;  17: return 15;  18: return 21;  19: return 8;
      20: return 18;  21: return 2;   22: return 61;  23: return 56;  24: return 14;
      default: return 0;
    endcase
  endfunction

  // Rotate toward the higher bit index: out[z] = in[(z - r) mod LANE_W].
  // The offset is constant per lane, so each call reduces to wiring.
  function automatic logic [LANE_W-1:0] rotl(input logic [LANE_W-1:0] lane, input int r);
    logic [2*LANE_W-1:0] dbl;
    dbl = {lane, lane} << (r % LANE_W);
    return dbl[2*LANE_W-1:LANE_W];
  endfunction

  // State, lane counter and working register; reset clears all of them.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      work_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
    end
  end

  // Next state: capture in IDLE, rotate the current lane group in ROTATE,
  // hold the result in DONE until the consumer takes it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          work_d  = bus.state_in;
          cnt_d   = '0;
          state_d = S_ROTATE;
        end
      end
      S_ROTATE: begin
        for (int i = 0; i < 25; i++) begin
          if (CNT_W'(i / LANES_PER_CYCLE) == cnt_q) begin
            work_d[i % 5][i / 5] = rotl(work_q[i % 5][i / 5], rho_raw(i));
          end
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(N_ITER - 1)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.busy      = (state_q == S_ROTATE) || (state_q == S_DONE);

`ifdef RHO_PI_EN
  state_arr_t pi_out;

  // Pi permutation as wiring: lane (x,y) moves to (y, (2x+3y) mod 5).
  always_comb begin
    pi_out = '0;
    for (int x = 0; x < 5; x++) begin
      for (int y = 0; y < 5; y++) begin
        pi_out[y][(2 * x + 3 * y) % 5] = work_q[x][y];
      end
    end
  end

  assign bus.state_out = pi_out;
`else
  assign bus.state_out = work_q;
`endif

endmodule

// File: tb/tb_rho_step_iter.sv
// Directed bench for rho_step_iter: a 64-bit/5-lane instance and an
// 8-bit/1-lane instance share one clock and reset.
module tb_rho_step_iter;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  rho_step_iter_if #(.LANE_W(64)) b64 ();
  rho_step_iter_if #(.LANE_W(8))  b8  ();

  rho_step_iter #(.LANE_W(64), .LANES_PER_CYCLE(5)) dut64 (
    .clk (clk),
    .rst (rst),
    .bus (b64.slave)
  );

  rho_step_iter #(.LANE_W(8), .LANES_PER_CYCLE(1)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (b8.slave)
  );

  // Reference rho offsets, indexed x + 5*y.
  int RHO [25] = '{0, 1, 62, 28, 27,
                   36, 44, 6, 55, 20,
                   3, 10, 43, 25, 39,
                   41, 45, 15, 21, 8,
                   18, 2, 61, 56, 14};

  int n_chk = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Where lane (x,y) of rho(A) appears on state_out.
  task automatic out_pos(input int x, input int y, output int ox, output int oy);
`ifdef RHO_PI_EN
    ox = y;
    oy = (2 * x + 3 * y) % 5;
`else
    ox = x;
    oy = y;
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [4:0][4:0][63:0] snap;
  logic [4:0][4:0][63:0] tmp;
  int cyc, ox, oy, bad;
  logic seen;

  initial begin
    b64.in_valid  = 1'b0;
    b64.state_in  = '0;
    b64.out_ready = 1'b1;
    b8.in_valid   = 1'b0;
    b8.state_in   = '0;
    b8.out_ready  = 1'b1;

    // Reset state
    rst = 1'b1;
    tick();
    check_val("rst_in_ready", b64.in_ready, 1'b1);
    check_val("rst_out_valid", b64.out_valid, 1'b0);
    check_val("rst_busy", b64.busy, 1'b0);
    tick();
    check_val("rst_state_out", |b64.state_out, 1'b0);
    check_val("rst_in_ready8", b8.in_ready, 1'b1);
    rst = 1'b0;

    // Test 1: single bit in lane (1,0)
    b64.state_in       = '0;
    b64.state_in[1][0] = 64'h1;
    b64.in_valid       = 1'b1;
    tick();
    b64.in_valid = 1'b0;
    b64.state_in = '0;
    check_val("t1_busy", b64.busy, 1'b1);
    check_val("t1_in_ready", b64.in_ready, 1'b0);
    cyc = 0;
    while (!b64.out_valid && cyc < 60) begin
      tick();
      cyc++;
    end
    check_val("t1_latency", cyc, 5);
    out_pos(1, 0, ox, oy);
    check_val("t1_lane", b64.state_out[ox][oy], 64'h2);
    tmp = b64.state_out;
    tmp[ox][oy] = '0;
    check_val("t1_others", |tmp, 1'b0);
    tick();
    check_val("t1_after_ov", b64.out_valid, 1'b0);
    check_val("t1_after_rdy", b64.in_ready, 1'b1);
    check_val("t1_after_busy", b64.busy, 1'b0);

    // Test 2 + backpressure: all lanes 1, consumer stalls for 10 cycles
    b64.out_ready = 1'b0;
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++)
        b64.state_in[x][y] = 64'h1;
    b64.in_valid = 1'b1;
    tick();
    b64.in_valid = 1'b0;
    cyc = 0;
    while (!b64.out_valid && cyc < 60) begin
      tick();
      cyc++;
    end
    check_val("t2_latency", cyc, 5);
    out_pos(0, 0, ox, oy);
    check_val("t2_l00", b64.state_out[ox][oy], 64'h1);
    out_pos(2, 0, ox, oy);
    check_val("t2_l20", b64.state_out[ox][oy], 64'h4000000000000000);
    out_pos(0, 1, ox, oy);
    check_val("t2_l01", b64.state_out[ox][oy], 64'h0000001000000000);
    out_pos(4, 4, ox, oy);
    check_val("t2_l44", b64.state_out[ox][oy], 64'h4000);
    bad = 0;
    for (int x = 0; x < 5; x++) begin
      for (int y = 0; y < 5; y++) begin
        out_pos(x, y, ox, oy);
        if (b64.state_out[ox][oy] !== (64'h1 << RHO[x + 5 * y])) bad++;
      end
    end
    check_val("t2_all_lanes_bad", bad, 0);
    snap = b64.state_out;
    for (int k = 0; k < 10; k++) begin
      tick();
      check_val("t4_hold_ov", b64.out_valid, 1'b1);
      check_val("t4_hold_rdy", b64.in_ready, 1'b0);
      check_val("t4_hold_stable", (b64.state_out == snap), 1'b1);
    end
    b64.out_ready = 1'b1;
    tick();
    check_val("t4_release_ov", b64.out_valid, 1'b0);
    check_val("t4_release_rdy", b64.in_ready, 1'b1);
    b64.state_in = '0;

    // Test 3: 8-bit lanes, one lane per cycle
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++)
        b8.state_in[x][y] = 8'h01;
    b8.in_valid = 1'b1;
    tick();
    b8.in_valid = 1'b0;
    cyc = 0;
    while (!b8.out_valid && cyc < 60) begin
      tick();
      cyc++;
    end
    check_val("t3_latency", cyc, 25);
    out_pos(2, 0, ox, oy);
    check_val("t3_l20", b8.state_out[ox][oy], 8'h40);
    out_pos(1, 1, ox, oy);
    check_val("t3_l11", b8.state_out[ox][oy], 8'h10);
    out_pos(0, 0, ox, oy);
    check_val("t3_l00", b8.state_out[ox][oy], 8'h01);
    tick();
    check_val("t3_after_rdy", b8.in_ready, 1'b1);

    // Test 5: reset during the third ROTATE cycle
    b64.state_in       = '0;
    b64.state_in[1][0] = 64'h1;
    b64.in_valid       = 1'b1;
    tick();
    b64.in_valid = 1'b0;
    b64.state_in = '0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_val("t5_ov", b64.out_valid, 1'b0);
    check_val("t5_busy", b64.busy, 1'b0);
    check_val("t5_rdy", b64.in_ready, 1'b1);
    check_val("t5_cleared", |b64.state_out, 1'b0);
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (b64.out_valid) seen = 1'b1;
    end
    check_val("t5_no_emit", seen, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
